muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set. It is the sequential companion to the single-cycle integer ALU.
- Sits in EX beside the ALU. The decoder issues M-extension ops to it over a valid/ready handshake, and the pipeline stalls until the result returns.
- Processes one radix-2 step per clock: shift-add for multiply, restoring for divide.
- A tag (destination register index) travels with each operation.

---
 rtl/muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M/RV64M multiply/divide unit.
// Ports: clk/rst/flush; in_* request handshake; out_* result handshake;
// busy for the hazard unit. Optional early-out: MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 5,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);
  localparam int W = DATA_WIDTH;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           op_q;
  logic                 neg1_q;
  logic                 neg2_q;
  logic                 div0_q;
  logic [W-1:0]         opnd_q;
  logic [2*W-1:0]       acc_q;
  logic [2*W-1:0]       acc_d;
  logic [W-1:0]         res_q;
  logic [W-1:0]         res_d;
  logic [TAG_WIDTH-1:0] tag_q;

  logic         accept;
  logic         last;
  logic         in_div;
  logic         sgn1;
  logic         sgn2;
  logic         in_neg1;
  logic         in_neg2;
  logic [W-1:0] mag1;
  logic [W-1:0] mag2;
  logic         early;
  logic [W-1:0] early_res;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign accept     = in_valid && in_ready && !flush;
  assign last       = (cnt_q == LAST);
  assign in_div     = in_op[2];

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (in_op)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      OP_MULHSU: sgn1 = 1'b1;
      default: ;
    endcase
  end

  assign in_neg1 = sgn1 && in_src1[W-1];
  assign in_neg2 = sgn2 && in_src2[W-1];
  assign mag1    = in_neg1 ? -in_src1 : in_src1;
  assign mag2    = in_neg2 ? -in_src2 : in_src2;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};
  logic in_div0;
  logic in_ovf;
  assign in_div0 = (in_src2 == '0);
  assign in_ovf  = !in_op[0] && (in_src1 == MIN_INT)
                && (in_src2 == ONES);

  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (in_div) begin
      if (in_div0) begin
        early     = 1'b1;
        early_res = in_op[1] ? in_src1 : ONES;
      end else if (in_ovf) begin
        early     = 1'b1;
        early_res = in_op[1] ? '0 : MIN_INT;
      end
    end else if (in_src1 == '0 || in_src2 == '0) begin
      early = 1'b1;
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // acc: mul = {partial product, multiplier}; div = {remainder, dividend->quotient}
  logic [W:0]   mul_hi;
  logic [W:0]   rem_sh;
  logic [W-1:0] rem_sub;
  logic         borrow;

  always_comb begin
    mul_hi = {1'b0, acc_q[2*W-1:W]};
    if (acc_q[0]) mul_hi = mul_hi + {1'b0, opnd_q};
    rem_sh  = acc_q[2*W-1:W-1];
    borrow  = (rem_sh < {1'b0, opnd_q});
    rem_sub = rem_sh[W-1:0] - opnd_q;
    if (op_q[2]) begin
      acc_d = {borrow ? rem_sh[W-1:0] : rem_sub, acc_q[W-2:0], !borrow};
    end else begin
      acc_d = {mul_hi, acc_q[W-1:1]};
    end
  end

  // high half of -P: ~P_hi plus the carry out of ~P_lo + 1
  logic [W-1:0] prod_hi;
  logic [W-1:0] quo;
  logic [W-1:0] rem_v;

  always_comb begin
    prod_hi = acc_d[2*W-1:W];
    if (neg1_q ^ neg2_q) begin
      prod_hi = ~acc_d[2*W-1:W] + W'(acc_d[W-1:0] == '0);
    end
    quo   = (neg1_q ^ neg2_q) ? -acc_d[W-1:0] : acc_d[W-1:0];
    rem_v = neg1_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
    res_d = '0;
    case (op_q)
      OP_MUL:                     res_d = acc_d[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_hi;
      OP_DIV, OP_DIVU:            res_d = div0_q ? ONES : quo;
      OP_REM, OP_REMU:            res_d = rem_v;
      default:                    res_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = early ? DONE : CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      op_q   <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      div0_q <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      tag_q  <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q   <= in_op;
      tag_q  <= in_tag;
      neg1_q <= in_neg1;
      neg2_q <= in_neg2;
      div0_q <= (in_src2 == '0);
      opnd_q <= in_div ? mag2 : mag1;
      acc_q  <= {{W{1'b0}}, in_div ? mag1 : mag2};
      cnt_q  <= '0;
      if (early) res_q <= early_res;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (last) res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector bench for muldiv_unit.
// Table of ops plus backpressure, flush and reset sequences.
module tb_muldiv_unit;
  localparam int W   = 32;
  localparam int TW  = 5;
  localparam int LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 33;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_src1;
  logic [W-1:0]  in_src2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    int            lat;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", in_ready, 1);
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_src1  = ~a;
    in_src2  = ~b;
    in_tag   = ~tag;
  endtask

  // call just after the accepting edge; cycle 1 is the one after it
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic saw_v;
    logic saw_b;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, LAT};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF, LAT};
    vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, LAT};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, LAT};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, LAT};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       LAT};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        LAT};
    vecs[8]  = '{3'd5, 32'h1234,     32'd0,        5'd9,  32'hFFFFFFFF, SP_LAT};
    vecs[9]  = '{3'd6, 32'h1234,     32'd0,        5'd10, 32'h1234,     SP_LAT};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, SP_LAT};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        SP_LAT};
    vecs[12] = '{3'd0, 32'd0,        32'h12345,    5'd13, 32'd0,        SP_LAT};
    vecs[13] = '{3'd4, 32'h1234,     32'd0,        5'd14, 32'hFFFFFFFF, SP_LAT};
    vecs[14] = '{3'd1, 32'hFFFFFFFF, 32'd2,        5'd15, 32'hFFFFFFFF, LAT};
    vecs[15] = '{3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd16, 32'd3,        LAT};
    vecs[16] = '{3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd17, 32'hFFFFFFFF, LAT};
    vecs[17] = '{3'd3, 32'h10000,    32'h10000,    5'd18, 32'd1,        LAT};
    vecs[18] = '{3'd7, 32'hFFFFFFFF, 32'd0,        5'd31, 32'hFFFFFFFF, SP_LAT};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_src1   = '0;
    in_src2   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_valid(lat);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_tag", i), out_tag, vecs[i].tag);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      take_result();
    end

    // backpressure in DONE with a competing request pending
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 5'd9);
    wait_valid(lat);
    chk("bp_latency", lat, LAT);
    in_op    = 3'd0;
    in_src1  = 32'd3;
    in_src2  = 32'd5;
    in_tag   = 5'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_result", i), out_result, 32'd14);
      chk($sformatf("bp%0d_tag", i), out_tag, 5'd9);
      chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
      @(negedge clk);
    end
    take_result();
    @(negedge clk);
    chk("bp_drop_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    wait_valid(lat);
    chk("bp_next_result", out_result, 32'd15);
    chk("bp_next_tag", out_tag, 5'd3);
    chk("bp_next_latency", lat, LAT);
    take_result();

    // flush in IDLE blocks an accept
    @(negedge clk);
    in_op    = 3'd0;
    in_src1  = 32'd2;
    in_src2  = 32'd3;
    in_tag   = 5'd2;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_busy", busy, 0);

    // flush at counter 10 with a request offered
    @(negedge clk);
    issue(3'd4, 32'd100, 32'd7, 5'd1);
    repeat (10) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_op    = 3'd0;
    in_src1  = 32'd2;
    in_src2  = 32'd3;
    in_tag   = 5'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_calc_busy", busy, 0);
    chk("flush_calc_valid", out_valid, 0);
    chk("flush_calc_ready", in_ready, 1);
    saw_v = 1'b0;
    saw_b = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_v |= out_valid;
      saw_b |= busy;
    end
    chk("flush_never_valid", saw_v, 0);
    chk("flush_never_busy", saw_b, 0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    issue(3'd0, 32'd7, 32'd3, 5'd7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_tag", out_tag, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release_ready", in_ready, 1);
    @(negedge clk);
    issue(3'd3, 32'h10000, 32'h10000, 5'd21);
    wait_valid(lat);
    chk("post_rst_result", out_result, 32'd1);
    chk("post_rst_tag", out_tag, 5'd21);
    chk("post_rst_latency", lat, LAT);
    take_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
